decode_issue: RTL and testbench

- RV32I decode/issue stage between instruction fetch and execute.
- Accepts one instruction per cycle and drives the register-file read addresses.
- Captures the combinational read data and presents a registered decoded bundle to execute over a valid/ready handshake.
- Holds a 32-entry write-pending scoreboard and stalls on read-after-write hazards until writeback retires the producer.

---
 rtl/decode_issue.sv | 205 ++++++++++++++++++++
 tb/tb_decode_issue.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue
// Purpose  : RV32I decode/issue stage with a write-pending scoreboard that
//            stalls read-after-write hazards until writeback retires the
//            producing instruction.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic [RF_AW-1:0] rf_addr_a,
    output logic [RF_AW-1:0] rf_addr_b,
    input  logic [XLEN-1:0]  rf_data_a,
    input  logic [XLEN-1:0]  rf_data_b,
    input  logic             wb_valid,
    input  logic [RF_AW-1:0] wb_dst,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [XLEN-1:0]  out_imm,
    output logic [RF_AW-1:0] out_rd,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic             out_reg_write
);

    localparam int         c_NREG     = 1 << RF_AW;
    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    logic [6:0]       w_opcode;
    logic [RF_AW-1:0] w_rd;
    logic [RF_AW-1:0] w_rs1;
    logic [RF_AW-1:0] w_rs2;
    logic [XLEN-1:0]  w_imm;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic             w_writes;
    logic             w_reg_write;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_fire;
    logic [c_NREG-1:0] w_busy_next;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_pc;
    logic [XLEN-1:0]  r_out_rs1_val;
    logic [XLEN-1:0]  r_out_rs2_val;
    logic [XLEN-1:0]  r_out_imm;
    logic [RF_AW-1:0] r_out_rd;
    logic [6:0]       r_out_opcode;
    logic [2:0]       r_out_funct3;
    logic [6:0]       r_out_funct7;
    logic             r_out_reg_write;
    logic [c_NREG-1:0] r_busy;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[7 +: RF_AW];
    assign w_rs1    = in_instr[15 +: RF_AW];
    assign w_rs2    = in_instr[20 +: RF_AW];

    always_comb begin
        w_imm     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        case (w_opcode)
            c_OP_REG: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
                w_imm     = XLEN'($signed(in_instr[31:20]));
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            c_OP_STORE: begin
                w_imm     = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_BR: begin
                w_imm     = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm    = XLEN'($signed({in_instr[31:12], 12'b0}));
                w_writes = 1'b1;
            end
            c_OP_JAL: begin
                w_imm    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                          in_instr[30:21], 1'b0}));
                w_writes = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_reg_write = w_writes && (w_rd != '0);

    // The held bundle has not set its busy bit yet, so it is checked separately.
    assign w_haz_rs1 = w_use_rs1 && (w_rs1 != '0) &&
                       (r_busy[w_rs1] || (r_out_valid && r_out_reg_write && (r_out_rd == w_rs1)));
    assign w_haz_rs2 = w_use_rs2 && (w_rs2 != '0) &&
                       (r_busy[w_rs2] || (r_out_valid && r_out_reg_write && (r_out_rd == w_rs2)));

    assign w_in_ready = (!r_out_valid || out_ready) &&
                        !(in_valid && (w_haz_rs1 || w_haz_rs2)) && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready && !flush;

    // Clear first, then set: a departing producer is younger than the retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (wb_valid && (wb_dst != '0)) begin
            w_busy_next[wb_dst] = 1'b0;
        end
        if (w_out_fire && r_out_reg_write) begin
            w_busy_next[r_out_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_pc        <= '0;
            r_out_rs1_val   <= '0;
            r_out_rs2_val   <= '0;
            r_out_imm       <= '0;
            r_out_rd        <= '0;
            r_out_opcode    <= '0;
            r_out_funct3    <= '0;
            r_out_funct7    <= '0;
            r_out_reg_write <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_out_pc        <= in_pc;
                r_out_rs1_val   <= rf_data_a;
                r_out_rs2_val   <= rf_data_b;
                r_out_imm       <= w_imm;
                r_out_rd        <= w_rd;
                r_out_opcode    <= w_opcode;
                r_out_funct3    <= in_instr[14:12];
                r_out_funct7    <= in_instr[31:25];
                r_out_reg_write <= w_reg_write;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign rf_addr_a     = w_rs1;
    assign rf_addr_b     = w_rs2;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_rs1_val   = r_out_rs1_val;
    assign out_rs2_val   = r_out_rs2_val;
    assign out_imm       = r_out_imm;
    assign out_rd        = r_out_rd;
    assign out_opcode    = r_out_opcode;
    assign out_funct3    = r_out_funct3;
    assign out_funct7    = r_out_funct7;
    assign out_reg_write = r_out_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue
// Purpose  : Scoreboard bench for decode_issue: directed hazard/immediate
//            scenarios followed by randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw;
    } bundle_t;

    logic        CLOCK_50;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_addr_a;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_reg_write;

    decode_issue #(.XLEN(32), .RF_AW(5)) dut (
        .CLOCK_50     (CLOCK_50),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_addr_a    (rf_addr_a),
        .rf_addr_b    (rf_addr_b),
        .rf_data_a    (rf_data_a),
        .rf_data_b    (rf_data_b),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_reg_write(out_reg_write)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int      checks = 0;
    int      errors = 0;
    bundle_t q[$];
    logic [4:0] issued[$];
    logic [31:0] m_busy;
    logic    m_valid;
    bundle_t m_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference decode: immediates built arithmetically from the ISA field positions.
    function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output bundle_t bd, output logic u1, output logic u2);
        logic [31:0] top;
        logic        wr;
        top = i[31] ? 32'hFFFF_FFFF : 32'h0;
        u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
        bd = '0;
        case (i[6:0])
            7'h33: begin u1 = 1; u2 = 1; wr = 1; end
            7'h13, 7'h03, 7'h67: begin
                u1 = 1; wr = 1;
                bd.imm = (top << 12) | 32'(i[31:20]);
            end
            7'h23: begin
                u1 = 1; u2 = 1;
                bd.imm = (top << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
            end
            7'h63: begin
                u1 = 1; u2 = 1;
                bd.imm = (top << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h37, 7'h17: begin
                wr = 1;
                bd.imm = i & 32'hFFFF_F000;
            end
            7'h6F: begin
                wr = 1;
                bd.imm = (top << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            default: ;
        endcase
        bd.pc   = pc;
        bd.rs1v = a;
        bd.rs2v = b;
        bd.rd   = i[11:7];
        bd.op   = i[6:0];
        bd.f3   = i[14:12];
        bd.f7   = i[31:25];
        bd.rw   = wr && (i[11:7] != 5'd0);
    endfunction

    // One clock of stimulus plus the reference-model update for that edge.
    task automatic cyc(input logic v, input logic [31:0] instr, input logic rdy,
                       input logic wbv, input logic [4:0] wbd, input logic fl,
                       output logic rdy_seen);
        bundle_t nb;
        logic u1, u2, haz, exp_rdy, acc, hs;
        logic [4:0] s1, s2;
        @(negedge CLOCK_50);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = $urandom;
        out_ready = rdy;
        wb_valid  = wbv;
        wb_dst    = wbd;
        flush     = fl;
        rf_data_a = $urandom;
        rf_data_b = $urandom;
        ref_decode(instr, in_pc, rf_data_a, rf_data_b, nb, u1, u2);
        s1 = instr[19:15];
        s2 = instr[24:20];
        haz = (u1 && s1 != 0 && (m_busy[s1] || (m_valid && m_b.rw && m_b.rd == s1))) ||
              (u2 && s2 != 0 && (m_busy[s2] || (m_valid && m_b.rw && m_b.rd == s2)));
        exp_rdy = (!m_valid || rdy) && !(v && haz) && !fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rf_addr", {22'd0, rf_addr_b, rf_addr_a}, {22'd0, s2, s1});
        rdy_seen = in_ready;
        acc = v && exp_rdy;
        hs  = m_valid && rdy && !fl;
        @(posedge CLOCK_50);
        if (wbv && wbd != 0) m_busy[wbd] = 1'b0;
        if (wbv) begin
            for (int k = 0; k < issued.size(); k++) begin
                if (issued[k] == wbd) begin
                    issued.delete(k);
                    break;
                end
            end
        end
        if (hs && m_b.rw) begin
            m_busy[m_b.rd] = 1'b1;
            issued.push_back(m_b.rd);
        end
        if (fl) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_b = nb;
            q.push_back(nb);
        end else if (hs) m_valid = 1'b0;
    endtask

    task automatic clear_model();
        m_busy  = '0;
        m_valid = 1'b0;
        m_b     = '0;
        q.delete();
        issued.delete();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        wb_valid = 0; wb_dst = 0; flush = 0; rf_data_a = 0; rf_data_b = 0;
    endtask

    task automatic clean_busy();
        logic r;
        for (int i = 1; i < 32; i++) cyc(0, 32'h0, 1, 1, 5'(i), 0, r);
    endtask

    // Monitor: every cycle the presented bundle must match the scoreboard head.
    initial begin
        bundle_t act;
        forever begin
            @(negedge CLOCK_50);
            #2;
            if (rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                if (out_valid === 1'b1 && q.size() != 0) begin
                    act = {out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd,
                           out_opcode, out_funct3, out_funct7, out_reg_write};
                    checks++;
                    if (act !== q[0]) begin
                        errors++;
                        $display("FAIL bundle actual=%h required=%h", act, q[0]);
                    end
                    if (out_ready || flush) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic r;
        logic [31:0] sa;
        logic        pend_v;
        logic [31:0] pend_i;
        logic [6:0]  ops [11];
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73};

        idle_inputs();
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_rw", 32'(out_reg_write), 32'd0);

        // Back-to-back, no hazard
        cyc(1, 32'h00500093, 1, 0, 0, 0, r);
        chk("addi_accept", 32'(r), 32'd1);
        #1;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rw", 32'(out_reg_write), 32'd1);
        cyc(1, 32'h00418133, 1, 0, 0, 0, r);
        sa = rf_data_a;
        chk("add_accept", 32'(r), 32'd1);
        #1;
        chk("add_rs1_val", out_rs1_val, sa);

        // RAW stall on x1 until the cycle after its writeback
        cyc(1, 32'h001082B3, 1, 0, 0, 0, r);
        chk("raw_stall", 32'(r), 32'd0);
        cyc(1, 32'h001082B3, 1, 1, 5'd1, 0, r);
        chk("raw_stall_wb_cycle", 32'(r), 32'd0);
        cyc(1, 32'h001082B3, 1, 0, 0, 0, r);
        sa = rf_data_a;
        chk("raw_accept_after_wb", 32'(r), 32'd1);
        #1;
        chk("raw_new_rf_data", out_rs1_val, sa);
        clean_busy();

        // Held-producer hazard on x7
        cyc(1, 32'h00100393, 0, 0, 0, 0, r);
        cyc(1, 32'h00038433, 0, 0, 0, 0, r);
        chk("held_stall", 32'(r), 32'd0);
        cyc(1, 32'h00038433, 1, 0, 0, 0, r);
        chk("held_stall_ready", 32'(r), 32'd0);
        cyc(1, 32'h00038433, 1, 0, 0, 0, r);
        chk("held_busy_stall", 32'(r), 32'd0);
        cyc(1, 32'h00000533, 1, 1, 5'd7, 0, r);
        chk("x0_no_stall", 32'(r), 32'd1);
        cyc(1, 32'h00038433, 1, 0, 0, 0, r);
        chk("held_release", 32'(r), 32'd1);
        clean_busy();

        // Immediates
        cyc(1, 32'hFE112E23, 1, 0, 0, 0, r);
        #1;
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_rw", 32'(out_reg_write), 32'd0);
        cyc(1, 32'hFE000EE3, 1, 0, 0, 0, r);
        #1;
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        cyc(1, 32'h12345037, 1, 0, 0, 0, r);
        #1;
        chk("lui_imm", out_imm, 32'h12345000);
        cyc(1, 32'h0080006F, 1, 0, 0, 0, r);
        #1;
        chk("jal_imm", out_imm, 32'd8);
        cyc(0, 32'h0, 1, 0, 0, 0, r);

        // Flush with out_ready high must not mark x3 busy
        cyc(1, 32'h00100193, 0, 0, 0, 0, r);
        cyc(0, 32'h0, 1, 0, 0, 1, r);
        #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        cyc(1, 32'h000185B3, 1, 0, 0, 0, r);
        chk("flush_no_busy", 32'(r), 32'd1);
        cyc(0, 32'h0, 1, 0, 0, 0, r);
        clean_busy();

        // Same-cycle set and clear of x4: set wins
        cyc(1, 32'h00100213, 0, 0, 0, 0, r);
        cyc(0, 32'h0, 1, 1, 5'd4, 0, r);
        cyc(1, 32'h00020633, 1, 0, 0, 0, r);
        chk("set_wins", 32'(r), 32'd0);
        cyc(1, 32'h00020633, 1, 1, 5'd4, 0, r);
        cyc(1, 32'h00020633, 1, 0, 0, 0, r);
        chk("set_then_clear", 32'(r), 32'd1);
        cyc(0, 32'h0, 1, 0, 0, 0, r);
        clean_busy();

        // Asynchronous reset mid-operation
        cyc(1, 32'h00100293, 0, 0, 0, 0, r);
        cyc(0, 32'h0, 1, 0, 0, 0, r);
        cyc(1, 32'h00100313, 0, 0, 0, 0, r);
        @(negedge CLOCK_50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_rd", 32'(out_rd), 32'd0);
        idle_inputs();
        clear_model();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        cyc(1, 32'h005286B3, 1, 0, 0, 0, r);
        chk("async_rst_busy", 32'(r), 32'd1);

        // Randomized traffic
        pend_v = 0;
        pend_i = 0;
        for (int n = 0; n < 3000; n++) begin
            logic wbv, fl, rdy;
            logic [4:0] wbd;
            if (!pend_v && ($urandom % 4) != 0) begin
                pend_i = $urandom;
                pend_i[6:0]   = ops[$urandom_range(0, 10)];
                pend_i[11:7]  = 5'($urandom_range(0, 7));
                pend_i[19:15] = 5'($urandom_range(0, 7));
                pend_i[24:20] = 5'($urandom_range(0, 7));
                pend_v = 1;
            end
            rdy = ($urandom % 3) != 0;
            fl  = ($urandom % 16) == 0;
            wbv = 0;
            wbd = 0;
            if (issued.size() != 0 && ($urandom % 3) == 0) begin
                wbv = 1;
                wbd = issued[$urandom_range(0, issued.size() - 1)];
            end else if (($urandom % 10) == 0) begin
                wbv = 1;
                wbd = 5'($urandom_range(0, 7));
            end
            cyc(pend_v, pend_i, rdy, wbv, wbd, fl, r);
            if (pend_v && r) pend_v = 0;
        end
        for (int n = 0; n < 4; n++) cyc(0, 32'h0, 1, 0, 0, 0, r);
        chk("drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
